// File: rtl/bldc_commutator.sv
// rtl/bldc_commutator.sv - six-step BLDC commutator with hall filter, position count and stall latch
// Optional brake input and logic are compiled in with BLDC_BRAKE_EN.
module bldc_commutator #(
    parameter int DUTY_CYCLE_WIDTH = 9,
    parameter int FILTER_CYCLES    = 16,
    parameter int STALL_CYCLES     = 2000000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [2:0]                  hall,
    input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    input  logic                        direction,
`ifdef BLDC_BRAKE_EN
    input  logic                        brake,
`endif
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_a,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_b,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_c,
    output logic                        high_z_a,
    output logic                        high_z_b,
    output logic                        high_z_c,
    output logic                        hall_fault,
    output logic                        stalled,
    output logic [15:0]                 hall_count
);

    localparam int            FW         = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FILTER_MAX = FW'(FILTER_CYCLES);
    localparam int            SW         = $clog2(STALL_CYCLES + 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYCLES);

    logic [2:0]                  sync1, sync2, filt_last, acc_code;
    logic [FW-1:0]               filt_cnt, filt_cnt_next;
    logic                        filt_eq, accept, code_change, acc_valid;
    logic [DUTY_CYCLE_WIDTH-1:0] duty_r;
    logic                        dir_r;
`ifdef BLDC_BRAKE_EN
    logic                        brake_r;
`endif
    logic [SW-1:0]               stall_cnt;
    logic                        stall_clear;
    logic [2:0]                  prev_pos, new_pos, prev_fwd, prev_rev;
    logic                        valid_step, step_fwd, step_rev;
    logic [2:0]                  tbl_pwm, tbl_low, nxt_pwm, nxt_hz;

    // Position of a code along the forward sequence; 7 marks an invalid code.
    function automatic logic [2:0] seq_pos(input logic [2:0] code);
        case (code)
            3'b101:  seq_pos = 3'd0;
            3'b100:  seq_pos = 3'd1;
            3'b110:  seq_pos = 3'd2;
            3'b010:  seq_pos = 3'd3;
            3'b011:  seq_pos = 3'd4;
            3'b001:  seq_pos = 3'd5;
            default: seq_pos = 3'd7;
        endcase
    endfunction

    // Run-length filter: acceptance fires once, on the clock the run reaches FILTER_CYCLES.
    always_comb begin
        filt_eq = (sync2 == filt_last);
        if (!filt_eq)
            filt_cnt_next = FW'(1);
        else if (filt_cnt == FILTER_MAX)
            filt_cnt_next = FILTER_MAX;
        else
            filt_cnt_next = filt_cnt + FW'(1);
        accept      = (filt_cnt_next == FILTER_MAX) && (!filt_eq || (filt_cnt != FILTER_MAX));
        code_change = accept && (!acc_valid || (sync2 != acc_code));
    end

    always_comb begin
        prev_pos   = seq_pos(acc_code);
        new_pos    = seq_pos(sync2);
        prev_fwd   = (prev_pos == 3'd5) ? 3'd0 : prev_pos + 3'd1;
        prev_rev   = (prev_pos == 3'd0) ? 3'd5 : prev_pos - 3'd1;
        valid_step = code_change && acc_valid && (prev_pos != 3'd7) && (new_pos != 3'd7);
        step_fwd   = valid_step && (new_pos == prev_fwd);
        step_rev   = valid_step && (new_pos == prev_rev);
        stall_clear = (duty_r == '0) || code_change;
`ifdef BLDC_BRAKE_EN
        stall_clear = stall_clear || brake_r;
`endif
    end

    // One-hot phase masks, bit 0 = A; Z phase is whatever is neither PWM nor LOW.
    always_comb begin
        tbl_pwm = 3'b000;
        tbl_low = 3'b000;
        case (acc_code)
            3'b101:  begin tbl_pwm = 3'b001; tbl_low = 3'b010; end
            3'b100:  begin tbl_pwm = 3'b001; tbl_low = 3'b100; end
            3'b110:  begin tbl_pwm = 3'b010; tbl_low = 3'b100; end
            3'b010:  begin tbl_pwm = 3'b010; tbl_low = 3'b001; end
            3'b011:  begin tbl_pwm = 3'b100; tbl_low = 3'b001; end
            3'b001:  begin tbl_pwm = 3'b100; tbl_low = 3'b010; end
            default: begin tbl_pwm = 3'b000; tbl_low = 3'b000; end
        endcase
        nxt_pwm = 3'b000;
        nxt_hz  = 3'b111;
`ifdef BLDC_BRAKE_EN
        if (brake_r)
            nxt_hz = 3'b000;
        else
`endif
        if (!acc_valid || hall_fault || stalled || (duty_r == '0)) begin
            nxt_pwm = 3'b000;
            nxt_hz  = 3'b111;
        end else begin
            nxt_pwm = dir_r ? tbl_low : tbl_pwm;
            nxt_hz  = ~(tbl_pwm | tbl_low);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= 3'b000;
            sync2      <= 3'b000;
            filt_last  <= 3'b000;
            filt_cnt   <= '0;
            acc_code   <= 3'b000;
            acc_valid  <= 1'b0;
            hall_fault <= 1'b0;
            hall_count <= 16'd0;
            stall_cnt  <= '0;
            stalled    <= 1'b0;
            duty_r     <= '0;
            dir_r      <= 1'b0;
`ifdef BLDC_BRAKE_EN
            brake_r    <= 1'b0;
`endif
            duty_a     <= '0;
            duty_b     <= '0;
            duty_c     <= '0;
            high_z_a   <= 1'b1;
            high_z_b   <= 1'b1;
            high_z_c   <= 1'b1;
        end else begin
            sync1     <= hall;
            sync2     <= sync1;
            filt_last <= sync2;
            filt_cnt  <= filt_cnt_next;
            if (accept) begin
                acc_code   <= sync2;
                acc_valid  <= 1'b1;
                hall_fault <= (sync2 == 3'b000) || (sync2 == 3'b111);
            end
            if (step_fwd)
                hall_count <= hall_count + 16'd1;
            else if (step_rev)
                hall_count <= hall_count - 16'd1;
            if (stall_clear)
                stall_cnt <= '0;
            else if (stall_cnt != STALL_MAX)
                stall_cnt <= stall_cnt + SW'(1);
            // Only a zero-duty clock releases the latch; hall motion does not.
            if (duty_r == '0)
                stalled <= 1'b0;
            else if (stall_cnt == STALL_MAX)
                stalled <= 1'b1;
            duty_r <= duty_cycle;
            dir_r  <= direction;
`ifdef BLDC_BRAKE_EN
            brake_r <= brake;
`endif
            duty_a   <= nxt_pwm[0] ? duty_r : '0;
            duty_b   <= nxt_pwm[1] ? duty_r : '0;
            duty_c   <= nxt_pwm[2] ? duty_r : '0;
            high_z_a <= nxt_hz[0];
            high_z_b <= nxt_hz[1];
            high_z_c <= nxt_hz[2];
        end
    end

endmodule

// File: tb/tb_bldc_commutator.sv
// tb/tb_bldc_commutator.sv - randomized bench for bldc_commutator against a behavioural model
module tb_bldc_commutator;

    localparam int W = 9;
    localparam int F = 16;
    localparam int S = 100;

    localparam logic [2:0] FWD_SEQ [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    localparam int PWM_BY_POS [6] = '{0, 0, 1, 1, 2, 2};
    localparam int LOW_BY_POS [6] = '{1, 2, 2, 0, 0, 1};

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [2:0]   hall = 3'b101;
    logic [W-1:0] duty_cycle = 9'd200;
    logic         direction = 1'b0;
`ifdef BLDC_BRAKE_EN
    logic         brake = 1'b0;
`endif
    logic [W-1:0] duty_a, duty_b, duty_c;
    logic         high_z_a, high_z_b, high_z_c;
    logic         hall_fault, stalled;
    logic [15:0]  hall_count;

    int errors = 0;
    int checks = 0;

    bldc_commutator #(
        .DUTY_CYCLE_WIDTH(W),
        .FILTER_CYCLES(F),
        .STALL_CYCLES(S)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hall(hall),
        .duty_cycle(duty_cycle),
        .direction(direction),
`ifdef BLDC_BRAKE_EN
        .brake(brake),
`endif
        .duty_a(duty_a),
        .duty_b(duty_b),
        .duty_c(duty_c),
        .high_z_a(high_z_a),
        .high_z_b(high_z_b),
        .high_z_c(high_z_c),
        .hall_fault(hall_fault),
        .stalled(stalled),
        .hall_count(hall_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]          s1;
        logic [2:0]          s2;
        logic [F:0][2:0]     hist;
        logic [5:0]          hist_n;
        logic                acc_valid;
        logic [2:0]          acc;
        logic                fault;
        logic [31:0]         since;
        logic                stalled;
        logic [15:0]         count;
        logic [W-1:0]        duty_r;
        logic                dir_r;
        logic                brake_r;
        logic [2:0][W-1:0]   e_duty;
        logic [2:0]          e_hz;
    } model_t;

    model_t m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pos_of(input logic [2:0] c);
        for (int i = 0; i < 6; i++)
            if (FWD_SEQ[i] == c) return i;
        return -1;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.e_hz = 3'b111;
        return r;
    endfunction

    function automatic model_t model_step(input model_t o, input logic [2:0] h,
                                          input logic [W-1:0] d, input logic dir, input logic brk);
        model_t n;
        int p, pw, lo, tmp, pa, pn;
        logic [2:0] v;
        logic same, acc_now, change;
        n = o;
        n.e_duty = '0;
        n.e_hz   = 3'b111;
        if (o.brake_r) begin
            n.e_hz = 3'b000;
        end else if (o.acc_valid && !o.fault && !o.stalled && o.duty_r != '0) begin
            p  = pos_of(o.acc);
            pw = PWM_BY_POS[p];
            lo = LOW_BY_POS[p];
            if (o.dir_r) begin tmp = pw; pw = lo; lo = tmp; end
            n.e_duty[pw] = o.duty_r;
            n.e_hz[pw]   = 1'b0;
            n.e_hz[lo]   = 1'b0;
        end
        if (o.duty_r == '0) n.stalled = 1'b0;
        else if (o.since >= S) n.stalled = 1'b1;
        v = o.s2;
        n.hist   = {o.hist[F-1:0], v};
        n.hist_n = (o.hist_n > 6'(F)) ? o.hist_n : o.hist_n + 6'd1;
        same = (n.hist_n >= 6'(F));
        for (int k = 0; k < F; k++)
            if (n.hist[k] != v) same = 1'b0;
        acc_now = same && ((n.hist_n == 6'(F)) || (n.hist[F] != v));
        change  = acc_now && (!o.acc_valid || v != o.acc);
        if (change && o.acc_valid) begin
            pa = pos_of(o.acc);
            pn = pos_of(v);
            if (pa >= 0 && pn >= 0) begin
                if (pn == (pa + 1) % 6) n.count = o.count + 16'd1;
                else if (pa == (pn + 1) % 6) n.count = o.count - 16'd1;
            end
        end
        if (o.duty_r == '0 || change || o.brake_r) n.since = 0;
        else n.since = o.since + 1;
        if (acc_now) begin
            n.acc       = v;
            n.acc_valid = 1'b1;
            n.fault     = (v == 3'b000) || (v == 3'b111);
        end
        n.s1      = h;
        n.s2      = o.s1;
        n.duty_r  = d;
        n.dir_r   = dir;
        n.brake_r = brk;
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset)
            m <= model_reset();
        else
`ifdef BLDC_BRAKE_EN
            m <= model_step(m, hall, duty_cycle, direction, brake);
`else
            m <= model_step(m, hall, duty_cycle, direction, 1'b0);
`endif
    end

    always @(negedge clock) begin
        chk("duty_a", duty_a, m.e_duty[0]);
        chk("duty_b", duty_b, m.e_duty[1]);
        chk("duty_c", duty_c, m.e_duty[2]);
        chk("high_z_a", high_z_a, m.e_hz[0]);
        chk("high_z_b", high_z_b, m.e_hz[1]);
        chk("high_z_c", high_z_c, m.e_hz[2]);
        chk("hall_fault", hall_fault, m.fault);
        chk("stalled", stalled, m.stalled);
        chk("hall_count", hall_count, m.count);
    end

    task automatic hold(input logic [2:0] c, input int n);
        @(negedge clock);
        hall = c;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int kind, p, cur;
        logic [15:0] cnt_saved;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_hz_a", high_z_a, 1);
        chk("reset_duty_a", duty_a, 0);
        chk("reset_fault", hall_fault, 0);
        reset = 1'b0;

        // Pin-to-output latency of 19 clocks
        repeat (18) @(posedge clock);
        #1;
        chk("lat18_hz_a", high_z_a, 1);
        chk("lat18_model_hz_a", m.e_hz[0], 1);
        @(posedge clock);
        #1;
        chk("lat19_duty_a", duty_a, 200);
        chk("lat19_duty_b", duty_b, 0);
        chk("lat19_hz_b", high_z_b, 0);
        chk("lat19_hz_c", high_z_c, 1);
        chk("lat19_model_duty_a", m.e_duty[0], 200);

        hold(3'b100, 25);
        hold(3'b110, 25);
        chk("count_fwd2", hall_count, 2);
        chk("model_count_fwd2", m.count, 2);
        hold(3'b100, 25);
        hold(3'b101, 25);
        chk("count_back0", hall_count, 0);
        direction = 1'b1;
        repeat (4) @(negedge clock);
        chk("rev_duty_b", duty_b, 200);
        chk("rev_duty_a", duty_a, 0);
        chk("rev_hz_a", high_z_a, 0);
        chk("rev_hz_c", high_z_c, 1);

        cnt_saved = hall_count;
        hold(3'b111, 10);
        hold(3'b101, 25);
        chk("glitch_count", hall_count, cnt_saved);
        chk("glitch_fault", hall_fault, 0);
        chk("glitch_duty_b", duty_b, 200);
        hold(3'b111, 25);
        chk("fault_set", hall_fault, 1);
        chk("fault_hz", {high_z_c, high_z_b, high_z_a}, 3'b111);

        duty_cycle = 9'd50;
        direction  = 1'b0;
        hold(3'b101, 20);
        for (int i = 0; i < 300 && stalled !== 1'b1; i++) @(negedge clock);
        chk("stall_set", stalled, 1);
        chk("model_stall_set", m.stalled, 1);
        repeat (2) @(negedge clock);
        chk("stall_hz", {high_z_c, high_z_b, high_z_a}, 3'b111);
        hold(3'b100, 25);
        chk("stall_hold", stalled, 1);
        duty_cycle = 9'd0;
        @(negedge clock);
        duty_cycle = 9'd50;
        repeat (3) @(negedge clock);
        chk("stall_clear", stalled, 0);
        chk("count_before_reset", hall_count, 1);

        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_duty_a", duty_a, 0);
        chk("async_hz", {high_z_c, high_z_b, high_z_a}, 3'b111);
        chk("async_count", hall_count, 0);
        chk("model_async_count", m.count, 0);
        @(negedge clock);
        reset = 1'b0;

`ifdef BLDC_BRAKE_EN
        hold(3'b111, 25);
        brake = 1'b1;
        repeat (3) @(negedge clock);
        chk("brake_hz", {high_z_c, high_z_b, high_z_a}, 3'b000);
        chk("brake_duty", {duty_c, duty_b, duty_a}, 0);
        brake = 1'b0;
`endif

        cur = 0;
        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 9);
            @(negedge clock);
            if (kind < 4) begin
                cur  = (cur + 1) % 6;
                hall = FWD_SEQ[cur];
            end else if (kind < 7) begin
                cur  = (cur + 5) % 6;
                hall = FWD_SEQ[cur];
            end else begin
                hall = 3'($urandom_range(0, 7));
                p = pos_of(hall);
                if (p >= 0) cur = p;
            end
            if ($urandom_range(0, 4) == 0) duty_cycle = '0;
            else duty_cycle = W'($urandom_range(1, 511));
            if ($urandom_range(0, 3) == 0) direction = ~direction;
`ifdef BLDC_BRAKE_EN
            brake = ($urandom_range(0, 7) == 0);
`endif
            if (it == 75) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 40)) @(negedge clock);
        end
        repeat (30) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bldc_commutator.md
BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

Interface
REQ-001 SHALL have parameter DUTY_CYCLE_WIDTH, default 9: width of the duty command and of each per-phase duty output.
REQ-002 SHALL have parameter FILTER_CYCLES, default 16: number of consecutive stable synchronized hall samples required to accept a new hall code.
REQ-003 SHALL have parameter STALL_CYCLES, default 2000000: number of clocks without an accepted hall change, at nonzero duty, that declares a stall.
REQ-004 Ports, in this order:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- hall  in  3  raw hall sensors {C,B,A}, asynchronous to clock.
- duty_cycle  in  DUTY_CYCLE_WIDTH  commanded magnitude.
- direction  in  1  0 = forward, 1 = reverse.
- brake  in  1  present only with BLDC_BRAKE_EN.
- duty_a, duty_b, duty_c  out  DUTY_CYCLE_WIDTH each  per-phase duty to the downstream phase drivers.
- high_z_a, high_z_b, high_z_c  out  1 each  per-phase float request to the phase drivers.
- hall_fault  out  1  accepted hall code is 000 or 111.
- stalled  out  1  stall latched.
- hall_count  out  16  signed hall-edge position count.

Function
REQ-005 SHALL pass hall through a 2-flop synchronizer; the filter SHALL accept the synchronized value after it has been equal for FILTER_CYCLES consecutive clocks; any change restarts the count.
REQ-006 SHALL register duty_cycle and direction each clock; the commutation outputs SHALL be registered, one clock after the accepted hall code or registered inputs.
REQ-007 Pin-to-output latency for a hall change SHALL be exactly 2 + FILTER_CYCLES + 1 clocks.
REQ-008 Forward table (hall CBA: PWM phase / LOW phase / Z phase): 101 A/B/C, 100 A/C/B, 110 B/C/A, 010 B/A/C, 011 C/A/B, 001 C/B/A.
REQ-009 Reverse SHALL swap the PWM and LOW phases of each row; the Z phase is unchanged.
REQ-010 PWM phase: duty = registered duty_cycle, high_z = 0. LOW phase: duty = 0, high_z = 0. Z phase: duty = 0, high_z = 1.
REQ-011 Registered duty_cycle == 0 SHALL force all three phases to high_z = 1, duty = 0 (coast).
REQ-012 Accepted code 000 or 111 SHALL assert hall_fault and force all phases high_z = 1; hall_fault SHALL clear on acceptance of a valid code.
REQ-013 Before the first accepted code after reset, all phases SHALL be high_z = 1, and hall_fault = 0.
REQ-014 The stall counter SHALL count clocks since the last accepted code change, saturating at STALL_CYCLES; it SHALL clear on an accepted change or when registered duty == 0.
REQ-015 stalled SHALL set when the counter reaches STALL_CYCLES with nonzero duty and force all phases high_z = 1.
REQ-016 stalled SHALL clear only after registered duty == 0 for one clock; a hall change alone SHALL NOT clear it.
REQ-017 hall_count SHALL increment on an accepted valid-to-valid transition one step along the forward sequence (101,100,110,010,011,001, wrapping), and decrement one step reverse, independent of direction.
REQ-018 hall_count SHALL NOT change on non-adjacent jumps or on transitions to or from invalid codes; it SHALL wrap modulo 2^16.
REQ-019 Priority, highest first: brake (if compiled), hall_fault / not-yet-accepted, stalled, duty == 0, table.
REQ-020 A direction change SHALL take effect on the next output update, with no intermediate state.

Reset
REQ-021 reset SHALL asynchronously set: synchronizer, filter and accepted-code state cleared and marked not accepted; all duty outputs 0; all high_z outputs 1; hall_fault 0; stalled 0; hall_count 0; stall counter 0.
REQ-022 Assertion mid-operation SHALL take effect immediately without waiting for clock; release SHALL restart the filter from zero.

Configuration
REQ-023 With macro BLDC_BRAKE_EN defined, the brake port SHALL exist; registered brake = 1 SHALL drive all phases duty = 0, high_z = 0 (all low sides on) and hold the stall counter clear.
REQ-024 Without BLDC_BRAKE_EN, the brake port and its logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-025 Reset, then hall = 101, duty = 200, direction = 0, FILTER_CYCLES = 16 -> exactly 19 clocks later: duty_a = 200, duty_b = 0 / high_z_b = 0, high_z_c = 1.
REQ-026 Hall 101 -> 100 -> 110 forward, then 110 -> 100 -> 101 -> hall_count = 2, then 0; direction = 1 on 101 -> duty_b = 200, duty_a = 0 / high_z_a = 0.
REQ-027 Hall glitch to 111 lasting 10 clocks -> no output change and no count; 111 held for 20 clocks -> hall_fault = 1 and all high_z = 1.
REQ-028 STALL_CYCLES = 100, duty = 50, hall frozen -> stalled = 1 at count 100 with all high_z = 1; hall change -> still stalled; duty = 0 for one clock -> stalled = 0.
REQ-029 Reset asserted mid-commutation between clock edges -> outputs immediately duty = 0 and high_z = 1, with hall_count = 0.
REQ-030 With BLDC_BRAKE_EN and brake = 1 during hall_fault -> all duty = 0 and all high_z = 0 after one clock.
